// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and the execution stage that
// reads it: opcode/operand/address types, the packed instruction word, the
// widened signed result type and the execution-stage state encoding.
package instr_register_pkg;

    localparam int OPERAND_W = 32;
    localparam int ADDRESS_W = 5;
    localparam int RESULT_W  = 2 * OPERAND_W;

    typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;

    typedef logic signed [OPERAND_W-1:0] operand_t;
    typedef logic        [ADDRESS_W-1:0] address_t;
    typedef logic signed [RESULT_W-1:0]  result_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, DIVIDE, OUTPUT} exec_state_t;

    function automatic logic is_div_op(input opcode_t opc);
        return (opc == DIV) || (opc == MOD);
    endfunction

endpackage

// File: rtl/instr_exec_divider.sv
// Iterative signed divider: restoring shift/subtract on operand magnitudes,
// one quotient bit per cycle, OP_W cycles per divide.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start                 load dividend/divisor and begin (divisor != 0)
//   dividend, divisor     signed OP_W operands, sampled on start
//   busy                  iteration in progress
//   done                  high in the cycle whose edge retires the last bit;
//                         quotient/remainder are final from the next cycle
//   quotient, remainder   signed 2*OP_W results, held until the next start
module instr_exec_divider #(
    parameter  int OP_W  = 32,
    localparam int RES_W = 2 * OP_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [OP_W-1:0]  dividend,
    input  logic signed [OP_W-1:0]  divisor,
    output logic                    busy,
    output logic                    done,
    output logic signed [RES_W-1:0] quotient,
    output logic signed [RES_W-1:0] remainder
);

    localparam int CW = $clog2(OP_W);
    localparam logic [CW-1:0] LAST_STEP = CW'(OP_W - 1);

    logic [OP_W-1:0] quo, rem, dvs;
    logic [CW-1:0]   cnt;
    logic            neg_q, neg_r;
    logic [OP_W:0]   partial, diff;
    logic signed [RES_W-1:0] q_mag, r_mag;

    // -2^(OP_W-1) negates to itself, which read unsigned is the right magnitude.
    function automatic logic [OP_W-1:0] mag(input logic signed [OP_W-1:0] v);
        return v[OP_W-1] ? -v : v;
    endfunction

    // Running remainder stays below the divisor (<= 2^(OP_W-1)), so one
    // extra bit is enough for the shifted partial and the borrow.
    assign partial = {rem, quo[OP_W-1]};
    assign diff    = partial - {1'b0, dvs};

    always_ff @(posedge clk) begin
        if (reset) begin
            busy  <= 1'b0;
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            rem   <= '0;
            quo   <= mag(dividend);
            dvs   <= mag(divisor);
            neg_q <= dividend[OP_W-1] ^ divisor[OP_W-1];
            neg_r <= dividend[OP_W-1];
        end else if (busy) begin
            if (!diff[OP_W]) begin
                rem <= diff[OP_W-1:0];
                quo <= {quo[OP_W-2:0], 1'b1};
            end else begin
                rem <= partial[OP_W-1:0];
                quo <= {quo[OP_W-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
            if (cnt == LAST_STEP) busy <= 1'b0;
        end
    end

    assign done = busy && (cnt == LAST_STEP);

    // Magnitudes zero-extend; the quotient of -2^(OP_W-1)/-1 stays positive.
    assign q_mag     = {{OP_W{1'b0}}, quo};
    assign r_mag     = {{OP_W{1'b0}}, rem};
    assign quotient  = neg_q ? -q_mag : q_mag;
    assign remainder = neg_r ? -r_mag : r_mag;

endmodule

// File: rtl/instr_exec_unit.sv
// Execution stage behind the instruction register. On start it walks the
// read port from first_addr to last_addr (inclusive, wrapping), evaluates
// each entry and offers a 64-bit signed result on a valid/ready port.
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   start, first_addr,         begin a run over [first_addr..last_addr];
//   last_addr                  start is only looked at in IDLE
//   read_pointer               register read address
//   instruction_word           combinational read data for read_pointer
//   busy, done                 run in progress / one-cycle end-of-run pulse
//   res_valid, res_ready       result handshake
//   res_addr, res_opcode,      source location, opcode, value and
//   res_value, res_div_zero    divide-by-zero flag of the offered result
module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter  int OP_W   = OPERAND_W,
    parameter  int ADDR_W = ADDRESS_W,
    localparam int RES_W  = 2 * OP_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       first_addr,
    input  logic [ADDR_W-1:0]       last_addr,
    output logic [ADDR_W-1:0]       read_pointer,
    input  instruction_t            instruction_word,
    output logic                    busy,
    output logic                    done,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ADDR_W-1:0]       res_addr,
    output opcode_t                 res_opcode,
    output logic signed [RES_W-1:0] res_value,
    output logic                    res_div_zero
);

    exec_state_t              state;
    logic [ADDR_W-1:0]        ptr, last;
    instruction_t             iw_q;
    logic signed [RES_W-1:0]  alu, alu_q, ext_a, ext_b;
    logic                     sel_div, is_mod;
    logic                     div_start, div_busy, div_done;
    logic signed [RES_W-1:0]  div_quo, div_rem;

    assign ext_a = RES_W'(iw_q.op_a);
    assign ext_b = RES_W'(iw_q.op_b);

    // Widened operands make ADD/SUB overflow-free and MULT exact.
    // DIV/MOD land in default so a divide-by-zero reports 0.
    always_comb begin
        alu = '0;
        case (iw_q.opc)
            PASSA:   alu = ext_a;
            PASSB:   alu = ext_b;
            ADD:     alu = ext_a + ext_b;
            SUB:     alu = ext_a - ext_b;
            MULT:    alu = ext_a * ext_b;
            default: alu = '0;
        endcase
    end

    assign div_start = (state == EXEC) && is_div_op(iw_q.opc) && (iw_q.op_b != '0);

    instr_exec_divider #(.OP_W(OP_W)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (iw_q.op_a),
        .divisor   (iw_q.op_b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            last         <= '0;
            iw_q         <= '{opc: ZERO, op_a: '0, op_b: '0};
            alu_q        <= '0;
            sel_div      <= 1'b0;
            is_mod       <= 1'b0;
            res_div_zero <= 1'b0;
            res_addr     <= '0;
            res_opcode   <= ZERO;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr   <= first_addr;
                        last  <= last_addr;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    iw_q     <= instruction_word;
                    res_addr <= ptr;
                    state    <= EXEC;
                end
                EXEC: begin
                    res_opcode   <= iw_q.opc;
                    alu_q        <= alu;
                    is_mod       <= (iw_q.opc == MOD);
                    res_div_zero <= is_div_op(iw_q.opc) && (iw_q.op_b == '0);
                    sel_div      <= div_start;
                    state        <= div_start ? DIVIDE : OUTPUT;
                end
                DIVIDE: begin
                    // An idle divider here can only mean it was never started.
                    if (div_done || !div_busy) state <= OUTPUT;
                end
                OUTPUT: begin
                    if (res_ready) begin
                        if (ptr == last) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            ptr   <= ptr + 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign read_pointer = ptr;
    assign busy         = (state != IDLE);
    assign res_valid    = (state == OUTPUT);
    // Divider registers hold after the last step, so this stays stable in OUTPUT.
    assign res_value    = sel_div ? (is_mod ? div_rem : div_quo) : alu_q;

endmodule

// File: tb/tb_instr_exec_unit.sv
module tb_instr_exec_unit;
    import instr_register_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               res_ready = 1'b0;
    logic [4:0]         first_addr = '0, last_addr = '0;
    logic [4:0]         read_pointer, res_addr;
    instruction_t       instruction_word;
    logic               busy, done, res_valid, res_div_zero;
    opcode_t            res_opcode;
    logic signed [63:0] res_value;

    instruction_t mem [32];
    int          checks = 0, failures = 0;
    int unsigned cyc_cnt = 0, t0 = 0, hs_cnt = 0;

    assign instruction_word = mem[read_pointer];

    instr_exec_unit dut (
        .clk(clk), .reset(reset), .start(start),
        .first_addr(first_addr), .last_addr(last_addr),
        .read_pointer(read_pointer), .instruction_word(instruction_word),
        .busy(busy), .done(done), .res_valid(res_valid), .res_ready(res_ready),
        .res_addr(res_addr), .res_opcode(res_opcode), .res_value(res_value),
        .res_div_zero(res_div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (res_valid && res_ready) hs_cnt <= hs_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Start pulse in cycle 0; returns at the negedge of cycle 1.
    task automatic kick(input logic [4:0] f, input logic [4:0] l);
        @(negedge clk);
        start = 1'b1; first_addr = f; last_addr = l; t0 = cyc_cnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for res_valid; lat = cycles since start, -1 on timeout.
    task automatic wait_valid(output int lat);
        int n = 0;
        do begin @(negedge clk); n++; end while (!res_valid && n < 200);
        lat = res_valid ? int'(cyc_cnt - t0) : -1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, res_valid, res_div_zero} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags: got %b want 0000", {busy, done, res_valid, res_div_zero});
        end
        checks++;
        if ({read_pointer, res_addr} !== 10'd0) begin
            failures++; $display("FAIL reset_addr: got rp=%0d ra=%0d want 0 0", read_pointer, res_addr);
        end
        checks++;
        if (res_value !== 64'sd0 || res_opcode !== ZERO) begin
            failures++; $display("FAIL reset_result: got %0d op=%0d want 0 op=0", res_value, res_opcode);
        end
        reset = 1'b0;
    endtask

    task automatic test_add();
        int lat;
        res_ready = 1'b1;
        kick(5'd0, 5'd0);
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL add_fetch: got valid=%b busy=%b want 0 1", res_valid, busy);
        end
        wait_valid(lat);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL add_latency: got %0d want 3", lat); end
        checks++;
        if (res_value !== 64'sd4 || res_addr !== 5'd0 || res_opcode !== ADD) begin
            failures++; $display("FAIL add_result: got %0d@%0d op=%0d want 4@0 op=3", res_value, res_addr, res_opcode);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL add_done: got done=%b valid=%b busy=%b want 1 0 0", done, res_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL add_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_mult_sub();
        int lat;
        kick(5'd1, 5'd2);
        checks++;
        if (read_pointer !== 5'd1) begin failures++; $display("FAIL ms_read_ptr: got %0d want 1", read_pointer); end
        wait_valid(lat);
        checks++;
        if (lat !== 3 || res_value !== -64'sd4294967296 || res_addr !== 5'd1 || res_opcode !== MULT) begin
            failures++; $display("FAIL mult: got lat=%0d %0d@%0d want lat=3 -4294967296@1", lat, res_value, res_addr);
        end
        wait_valid(lat);
        checks++;
        if (lat !== 6 || res_value !== -64'sd2147483649 || res_addr !== 5'd2) begin
            failures++; $display("FAIL sub: got lat=%0d %0d@%0d want lat=6 -2147483649@2", lat, res_value, res_addr);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL ms_done: got %b want 1", done); end
    endtask

    task automatic test_divide();
        int lat;
        kick(5'd3, 5'd4);
        repeat (5) @(negedge clk);
        checks++;
        if (read_pointer !== 5'd3 || res_valid !== 1'b0) begin
            failures++; $display("FAIL div_hold: got rp=%0d valid=%b want 3 0", read_pointer, res_valid);
        end
        wait_valid(lat);
        checks++;
        if (lat !== 35 || res_value !== -64'sd3 || res_opcode !== DIV || res_div_zero !== 1'b0) begin
            failures++; $display("FAIL div: got lat=%0d %0d op=%0d dz=%b want lat=35 -3 op=6 dz=0", lat, res_value, res_opcode, res_div_zero);
        end
        wait_valid(lat);
        checks++;
        if (lat !== 70 || res_value !== -64'sd2 || res_opcode !== MOD || res_addr !== 5'd4) begin
            failures++; $display("FAIL mod: got lat=%0d %0d op=%0d@%0d want lat=70 -2 op=7@4", lat, res_value, res_opcode, res_addr);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL div_done: got %b want 1", done); end
    endtask

    task automatic test_edge_ops();
        int lat;
        logic signed [63:0] ev [5] = '{64'sd0, 64'sd11, 64'sd0, 64'sd2147483648, -64'sd5};
        logic               ez [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        kick(5'd5, 5'd9);
        for (int i = 0; i < 5; i++) begin
            wait_valid(lat);
            checks++;
            if (lat < 0 || res_addr !== 5'(5 + i) || res_value !== ev[i] || res_div_zero !== ez[i]) begin
                failures++;
                $display("FAIL edge_op_%0d: got lat=%0d %0d@%0d dz=%b want %0d@%0d dz=%b",
                         i, lat, res_value, res_addr, res_div_zero, ev[i], 5 + i, ez[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL edge_done: got %b want 1", done); end
    endtask

    task automatic test_wrap_stall();
        int lat;
        int unsigned hs0;
        logic [4:0]         ea [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
        logic signed [63:0] ev [4] = '{64'sd3, 64'sd6, 64'sd4, -64'sd4294967296};
        res_ready = 1'b0;
        hs0 = hs_cnt;
        kick(5'd30, 5'd1);
        for (int i = 0; i < 4; i++) begin
            wait_valid(lat);
            for (int s = 0; s < 5; s++) begin
                checks++;
                if (res_valid !== 1'b1 || res_addr !== ea[i] || res_value !== ev[i]) begin
                    failures++;
                    $display("FAIL wrap_stall_%0d_%0d: got v=%b %0d@%0d want v=1 %0d@%0d",
                             i, s, res_valid, res_value, res_addr, ev[i], ea[i]);
                end
                if (s < 4) @(negedge clk);
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            checks++;
            if (res_valid !== 1'b0 || done !== (i == 3)) begin
                failures++; $display("FAIL wrap_release_%0d: got v=%b done=%b want v=0 done=%b", i, res_valid, done, i == 3);
            end
        end
        checks++;
        if (hs_cnt - hs0 !== 4) begin failures++; $display("FAIL wrap_handshakes: got %0d want 4", hs_cnt - hs0); end
    endtask

    task automatic test_reset_mid_divide();
        int lat;
        res_ready = 1'b1;
        kick(5'd3, 5'd3);
        repeat (11) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || res_valid !== 1'b0) begin
            failures++; $display("FAIL mid_div_busy: got busy=%b valid=%b want 1 0", busy, res_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || read_pointer !== 5'd0 || res_value !== 64'sd0) begin
            failures++; $display("FAIL mid_div_reset: got busy=%b v=%b rp=%0d val=%0d want 0 0 0 0", busy, res_valid, read_pointer, res_value);
        end
        reset = 1'b0;
        kick(5'd0, 5'd0);
        start = 1'b1; first_addr = 5'd9; last_addr = 5'd9;
        @(negedge clk);
        start = 1'b0;
        wait_valid(lat);
        checks++;
        if (lat !== 3 || res_value !== 64'sd4 || res_addr !== 5'd0) begin
            failures++; $display("FAIL restart: got lat=%0d %0d@%0d want lat=3 4@0", lat, res_value, res_addr);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            failures++; $display("FAIL ignored_start: got busy=%b valid=%b want 0 0", busy, res_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '{opc: ZERO, op_a: '0, op_b: '0};
        mem[0]  = '{opc: ADD,   op_a: 32'sd7,       op_b: -32'sd3};
        mem[1]  = '{opc: MULT,  op_a: -32'sd65536,  op_b: 32'sd65536};
        mem[2]  = '{opc: SUB,   op_a: 32'h80000000, op_b: 32'sd1};
        mem[3]  = '{opc: DIV,   op_a: -32'sd17,     op_b: 32'sd5};
        mem[4]  = '{opc: MOD,   op_a: -32'sd17,     op_b: 32'sd5};
        mem[5]  = '{opc: DIV,   op_a: 32'sd9,       op_b: 32'sd0};
        mem[6]  = '{opc: PASSA, op_a: 32'sd11,      op_b: 32'sd99};
        mem[7]  = '{opc: opcode_t'(4'hC), op_a: 32'sd5, op_b: 32'sd6};
        mem[8]  = '{opc: DIV,   op_a: 32'h80000000, op_b: -32'sd1};
        mem[9]  = '{opc: PASSB, op_a: 32'sd8,       op_b: -32'sd5};
        mem[30] = '{opc: ADD,   op_a: 32'sd1,       op_b: 32'sd2};
        mem[31] = '{opc: SUB,   op_a: 32'sd10,      op_b: 32'sd4};

        test_reset();
        test_add();
        test_mult_sub();
        test_divide();
        test_edge_ops();
        test_wrap_stall();
        test_reset_mid_divide();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
